// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared state encodings, datapath select codes and opcodes for
//               the multicycle controller and its ALU decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] c_ST_FETCH  = 4'd0;
    localparam logic [ST_W-1:0] c_ST_DECODE = 4'd1;
    localparam logic [ST_W-1:0] c_ST_EXEC_R = 4'd2;
    localparam logic [ST_W-1:0] c_ST_ADDR   = 4'd3;
    localparam logic [ST_W-1:0] c_ST_MEM_RD = 4'd4;
    localparam logic [ST_W-1:0] c_ST_MEM_WR = 4'd5;
    localparam logic [ST_W-1:0] c_ST_WB_R   = 4'd6;
    localparam logic [ST_W-1:0] c_ST_WB_LD  = 4'd7;
    localparam logic [ST_W-1:0] c_ST_BRANCH = 4'd8;
    localparam logic [ST_W-1:0] c_ST_TRAP   = 4'd9;

    localparam logic [1:0] c_ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] c_ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] c_ALU_OP_FUNCT  = 2'b10;

    localparam logic [1:0] c_SRC_A_PC     = 2'b00;
    localparam logic [1:0] c_SRC_A_RS1    = 2'b01;
    localparam logic [1:0] c_SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] c_SRC_B_RS2    = 2'b00;
    localparam logic [1:0] c_SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] c_SRC_B_IMM    = 2'b10;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle RISC-style control FSM with memory handshake,
//               wait timeout and sticky trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       trap
);

    localparam int              CNT_W        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_WAIT_LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             w_mem_wait;
    logic             w_timeout;

    // The limit is one below MEM_TIMEOUT so the trap lands on the edge that
    // closes the MEM_TIMEOUT-th waiting cycle; a late mem_ready still wins.
    assign w_mem_wait = (state_q inside {c_ST_FETCH, c_ST_MEM_RD, c_ST_MEM_WR}) && !mem_ready;
    assign w_timeout  = w_mem_wait && (wait_cnt_q == c_WAIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = (w_mem_wait && !w_timeout) ? wait_cnt_q + CNT_W'(1) : '0;
        case (state_q)
            c_ST_FETCH: begin
                if (mem_ready)      state_d = c_ST_DECODE;
                else if (w_timeout) state_d = c_ST_TRAP;
            end
            c_ST_DECODE: begin
                case (opcode)
                    c_OP_RTYPE:            state_d = c_ST_EXEC_R;
                    c_OP_LOAD, c_OP_STORE: state_d = c_ST_ADDR;
                    c_OP_BRANCH:           state_d = c_ST_BRANCH;
                    default:               state_d = c_ST_TRAP;
                endcase
            end
            c_ST_EXEC_R: state_d = c_ST_WB_R;
            c_ST_ADDR:   state_d = (opcode == c_OP_STORE) ? c_ST_MEM_WR : c_ST_MEM_RD;
            c_ST_MEM_RD: begin
                if (mem_ready)      state_d = c_ST_WB_LD;
                else if (w_timeout) state_d = c_ST_TRAP;
            end
            c_ST_MEM_WR: begin
                if (mem_ready)      state_d = c_ST_FETCH;
                else if (w_timeout) state_d = c_ST_TRAP;
            end
            c_ST_WB_R, c_ST_WB_LD, c_ST_BRANCH: state_d = c_ST_FETCH;
            c_ST_TRAP:   state_d = c_ST_TRAP;
            default:     state_d = c_ST_TRAP;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = c_SRC_A_PC;
        alu_src_b  = c_SRC_B_RS2;
        alu_op     = c_ALU_OP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            c_ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = c_SRC_A_PC;
                alu_src_b = c_SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            c_ST_DECODE: begin
                alu_src_a = c_SRC_A_OLD_PC;
                alu_src_b = c_SRC_B_IMM;
            end
            c_ST_EXEC_R: begin
                alu_src_a = c_SRC_A_RS1;
                alu_src_b = c_SRC_B_RS2;
                alu_op    = c_ALU_OP_FUNCT;
            end
            c_ST_ADDR: begin
                alu_src_a = c_SRC_A_RS1;
                alu_src_b = c_SRC_B_IMM;
            end
            c_ST_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            c_ST_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            c_ST_WB_R: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            c_ST_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            c_ST_BRANCH: begin
                alu_src_a  = c_SRC_A_RS1;
                alu_src_b  = c_SRC_B_RS2;
                alu_op     = c_ALU_OP_BRANCH;
                pc_src     = 1'b1;
                pc_write   = zero;
                instr_done = 1'b1;
            end
            c_ST_TRAP: trap = 1'b1;
            default:   trap = 1'b1;
        endcase
        // Reset must silence the bus and every strobe at once, not at the next edge.
        if (!rst_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

endmodule

`default_nettype wire
